mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It consumes the EX/MEM bundle (`exmem_t`), drives the data-memory bus for loads and stores, and aligns and extends load data. It also owns the MEM/WB pipeline register and produces the `memwb_t` bundle. While a bus transaction is outstanding it stalls the pipeline, and it drops misaligned accesses.

## Interface
Parameters:
- `XLEN`, 32, data/address width; only 32 is supported.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `exmem_i`  in  `exmem_t`  EX/MEM bundle; held stable by upstream while `stall_m_o`=1.
- `exmem_valid_i`  in  1  `exmem_i` carries a live instruction.
- `stall_m_o`  out  1  combinational; stalls F/D/E/M for this cycle.
- `misalign_o`  out  1  one-cycle registered pulse: misaligned access dropped.
- `memwb_o`  out  `memwb_t`  registered MEM/WB bundle.
- `memwb_valid_o`  out  1  `memwb_o` is a live instruction.
- `dmem_req_o`  out  1  bus request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word-aligned address (`ALUResult[31:2]`,2'b00).
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`  in  1  load response valid; asserted at least 1 cycle after `gnt`.
- `dmem_rdata_i`  in  32  load response word.

## Operation
- **Access type.** An instruction is a memory op when `exmem_valid_i` is set and either `MemWrite`=1 (store) or `ResultSrc`=2'b01 (load). All other valid instructions pass straight through.
- **Alignment rules.**
  - Offset: `a`=`ALUResult[1:0]`.
  - Halfword (funct3 x01) is misaligned if `a[0]`=1.
  - Word (funct3 010) is misaligned if `a`≠0.
  - A misaligned access raises no request, does not stall, pulses `misalign_o`, and retires with `RegWrite`=0.
- **Stores.**
  - SB: `be`=1<<a, `wdata`={4{WriteData[7:0]}}.
  - SH: `be`=4'b0011<<a, `wdata`={2{WriteData[15:0]}}.
  - SW: `be`=4'b1111, `wdata`=WriteData.
- **Loads.**
  - `be` is as for stores; `we`=0.
  - On `rvalid`, select byte/half at offset `a` from `rdata`.
  - LB/LH sign-extend; LBU (100)/LHU (101) zero-extend; LW passes the word through.
  - Result goes to `load_data`.
- **FSM.**
  - IDLE: `dmem_req_o` = memory op and aligned. On `gnt`, a store completes; a load moves to WAIT_R. Without `gnt`, stay in IDLE with the request held and address/data stable.
  - WAIT_R: `dmem_req_o`=0. On `rvalid`, the load completes and the FSM returns to IDLE.
- **Stall.** `stall_m_o` = aligned memory op and not (store & `gnt` in IDLE) and not (`rvalid` in WAIT_R).
- **MEM/WB register.**
  - When `stall_m_o`=0: `memwb_o` takes RegWrite (cleared if misaligned), ResultSrc, ALUResult, load_data, ImmExt, PCPlus4, Rd; `memwb_valid_o` takes `exmem_valid_i`.
  - When `stall_m_o`=1: `memwb_valid_o`<=0 and `memwb_o.RegWrite`<=0, inserting a bubble.
- **Stray responses.** `dmem_rvalid_i` seen in IDLE is ignored.

## Timing
- **Reset values.** state=IDLE; `memwb_o`=all zeros; `memwb_valid_o`=0; `misalign_o`=0. Combinational outputs evaluate to 0 when no valid memory op is present.
- **Latency.**
  - Non-memory or misaligned instruction: `memwb_o` is valid at the next edge.
  - Store granted in cycle N: `memwb_o` valid after edge N.
  - Load granted in N with `rvalid` in N+k (k≥1): stall asserted for cycles N..N+k−1; `memwb_o` valid after edge N+k.
- **Handshake.** Request signals must stay stable from request until `gnt`. Only one transaction is outstanding at a time.
- **Reset mid-operation.** The FSM returns to IDLE and the pending response is discarded.
- **Combinational path.** `stall_m_o` depends combinationally on `dmem_gnt_i` and `dmem_rvalid_i`.

## Test plan
- **SW, same-cycle grant.** SW with `ALUResult`=0x100, `WriteData`=0xDEADBEEF, `gnt` in the same cycle -> `req`=1, `we`=1, `addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF, no stall, `memwb_valid_o`=1 next cycle.
- **LB sign extension.** LB at 0x103, `rdata`=0x80FF_0000, `gnt` in cycle 0, `rvalid` in cycle 2 -> `be`=1000, stall high for cycles 0-1, `load_data`=0xFFFFFF80, one bubble then valid.
- **LHU zero extension.** LHU at 0x102, `rdata`=0xBEEF_1234 -> `be`=1100, `load_data`=0x0000BEEF.
- **Misaligned word.** LW at 0x101 -> no `req`, `misalign_o` pulses once, `memwb_o.RegWrite`=0, no stall.
- **Delayed grant.** SB at 0x202 with `WriteData`=0x55, `gnt` withheld for 3 cycles -> `req` held with `be`=0100 and `wdata`=0x55555555 stable, stall for 3 cycles, completes on the `gnt` cycle.
- **Reset during load.** `rst_n` asserted while in WAIT_R -> all outputs return to reset values immediately; a late `rvalid` after reset is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data bus for loads/stores, aligns and
// extends load data, and owns the MEM/WB pipeline register.
package mem_stage_pkg;
  typedef struct packed {
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ImmExt;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
  } exmem_t;

  typedef struct packed {
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult;
    logic [31:0] load_data;
    logic [31:0] ImmExt;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
  } memwb_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  exmem_t          exmem_i,
  input  logic            exmem_valid_i,
  output logic            stall_m_o,
  output logic            misalign_o,
  output memwb_t          memwb_o,
  output logic            memwb_valid_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  typedef enum logic {IDLE = 1'b0, WAIT_R = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  a;
  logic        is_store, is_load, mem_op, misaligned, aligned_op;
  logic [3:0]  be;
  logic [31:0] wdata, byte_shift, half_shift, load_data;

  assign a          = exmem_i.ALUResult[1:0];
  assign is_store   = exmem_valid_i & exmem_i.MemWrite;
  assign is_load    = exmem_valid_i & ~exmem_i.MemWrite & (exmem_i.ResultSrc == 2'b01);
  assign mem_op     = is_store | is_load;
  assign aligned_op = mem_op & ~misaligned;

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = exmem_i.WriteData;
    case (exmem_i.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << a;
        wdata = {4{exmem_i.WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = a[0];
        be         = 4'b0011 << a;
        wdata      = {2{exmem_i.WriteData[15:0]}};
      end
      default: misaligned = (a != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (aligned_op && is_load && dmem_gnt_i) state_next = WAIT_R;
      WAIT_R:  if (dmem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o = 1'b0;
    stall_m_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        dmem_req_o = aligned_op;
        stall_m_o  = aligned_op & ~(is_store & dmem_gnt_i);
      end
      WAIT_R:  stall_m_o = aligned_op & ~dmem_rvalid_i;
      default: ;
    endcase
  end

  assign dmem_we_o    = dmem_req_o & is_store;
  assign dmem_addr_o  = dmem_req_o ? {exmem_i.ALUResult[31:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? wdata : '0;

  assign byte_shift = dmem_rdata_i >> {a, 3'b000};
  assign half_shift = dmem_rdata_i >> {a[1], 4'b0000};

  // Only a response that completes the outstanding load yields data; strays read as zero.
  always_comb begin
    load_data = '0;
    if (state_reg == WAIT_R && dmem_rvalid_i) begin
      case (exmem_i.funct3)
        3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
        3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
        3'b100:  load_data = {24'h0, byte_shift[7:0]};
        3'b101:  load_data = {16'h0, half_shift[15:0]};
        default: load_data = dmem_rdata_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_o       <= '0;
      memwb_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= mem_op & misaligned;
      if (stall_m_o) begin
        memwb_valid_o    <= 1'b0;
        memwb_o.RegWrite <= 1'b0;
      end else begin
        memwb_valid_o     <= exmem_valid_i;
        memwb_o.RegWrite  <= exmem_i.RegWrite & ~(mem_op & misaligned);
        memwb_o.ResultSrc <= exmem_i.ResultSrc;
        memwb_o.ALUResult <= exmem_i.ALUResult;
        memwb_o.load_data <= load_data;
        memwb_o.ImmExt    <= exmem_i.ImmExt;
        memwb_o.PCPlus4   <= exmem_i.PCPlus4;
        memwb_o.Rd        <= exmem_i.Rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of bus transactions with a retire scoreboard,
// plus hand-written reset-during-load and stray-response sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  exmem_t      exmem_i = '0;
  logic        exmem_valid_i = 1'b0;
  logic        stall_m_o, misalign_o, memwb_valid_o;
  memwb_t      memwb_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  int total = 0;
  int bad   = 0;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .exmem_i(exmem_i), .exmem_valid_i(exmem_valid_i),
    .stall_m_o(stall_m_o), .misalign_o(misalign_o), .memwb_o(memwb_o),
    .memwb_valid_o(memwb_valid_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // kind: 0 = ALU pass-through, 1 = load, 2 = store
  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct packed {
    logic        rw;
    logic        chk_load;
    logic [31:0] alu;
    logic [31:0] load;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[12];

  // Retire monitor: every valid MEM/WB beat must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (memwb_valid_o) begin
      if (sbq.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        $display("retire rd=%0d alu=%h rw=%0d load=%h", memwb_o.Rd, memwb_o.ALUResult,
                 memwb_o.RegWrite, memwb_o.load_data);
        check("wb_rd", {27'd0, memwb_o.Rd}, {27'd0, e.rd});
        check("wb_alu", memwb_o.ALUResult, e.alu);
        check("wb_regwrite", {31'd0, memwb_o.RegWrite}, {31'd0, e.rw});
        if (e.chk_load) check("wb_load_data", memwb_o.load_data, e.load);
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    exmem_t ex;
    exp_t   e;
    int     gd;
    ex           = '0;
    ex.RegWrite  = (v.kind != 2);
    ex.ResultSrc = (v.kind == 1) ? 2'b01 : 2'b00;
    ex.MemWrite  = (v.kind == 2);
    ex.funct3    = v.f3;
    ex.ALUResult = v.alu;
    ex.WriteData = v.wd;
    ex.ImmExt    = 32'h1000 + idx;
    ex.PCPlus4   = 32'h4 * idx;
    ex.Rd        = 5'(idx + 1);
    e.rw         = ex.RegWrite & ~v.mis;
    e.chk_load   = (v.kind == 1) && !v.mis;
    e.alu        = v.alu;
    e.load       = v.exp_load;
    e.rd         = ex.Rd;

    @(negedge clk);
    exmem_i       = ex;
    exmem_valid_i = 1'b1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    sbq.push_back(e);
    $display("txn %0d kind=%0d f3=%b addr=%h", idx, v.kind, v.f3, v.alu);

    if (v.kind == 0 || v.mis) begin
      #1;
      check("nomem_req", {31'd0, dmem_req_o}, 32'd0);
      check("nomem_stall", {31'd0, stall_m_o}, 32'd0);
      @(posedge clk); #1;
      check("misalign_pulse", {31'd0, misalign_o}, {31'd0, v.mis});
      return;
    end

    gd = v.gnt_dly;
    for (int c = 0; c <= gd; c++) begin
      if (c > 0) @(negedge clk);
      dmem_gnt_i = (c == gd);
      #1;
      check("req", {31'd0, dmem_req_o}, 32'd1);
      check("we", {31'd0, dmem_we_o}, {31'd0, (v.kind == 2)});
      check("addr", dmem_addr_o, {v.alu[31:2], 2'b00});
      check("be", {28'd0, dmem_be_o}, {28'd0, v.be});
      if (v.kind == 2) check("wdata", dmem_wdata_o, v.exp_wdata);
      check("stall_req", {31'd0, stall_m_o}, {31'd0, !((v.kind == 2) && (c == gd))});
    end
    if (v.kind == 1) begin
      for (int j = 1; j <= v.rv_dly; j++) begin
        @(negedge clk);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = (j == v.rv_dly);
        dmem_rdata_i  = (j == v.rv_dly) ? v.rdata : 32'h0BAD_0BAD;
        #1;
        check("wait_req", {31'd0, dmem_req_o}, 32'd0);
        check("stall_wait", {31'd0, stall_m_o}, {31'd0, (j != v.rv_dly)});
      end
    end
    @(posedge clk); #1;
    check("misalign_idle", {31'd0, misalign_o}, 32'd0);
  endtask

  initial begin
    //          kind f3      alu           wd            rdata        gd rd mis be       wdata         load
    tbl[0]  = '{2, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{1, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 0, 2, 0, 4'b1000, 32'h0,       32'hFFFF_FF80};
    tbl[2]  = '{1, 3'b101, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 1, 1, 0, 4'b1100, 32'h0,       32'h0000_BEEF};
    tbl[3]  = '{1, 3'b010, 32'h0000_0101, 32'h0,         32'h0,       0, 0, 1, 4'b0000, 32'h0,         32'h0};
    tbl[4]  = '{2, 3'b000, 32'h0000_0202, 32'h0000_0055, 32'h0,       3, 0, 0, 4'b0100, 32'h5555_5555, 32'h0};
    tbl[5]  = '{0, 3'b000, 32'h0000_1234, 32'h0,         32'h0,       0, 0, 0, 4'b0000, 32'h0,         32'h0};
    tbl[6]  = '{1, 3'b001, 32'h0000_0100, 32'h0,         32'h1234_8001, 0, 1, 0, 4'b0011, 32'h0,       32'hFFFF_8001};
    tbl[7]  = '{1, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_A500, 0, 1, 0, 4'b0010, 32'h0,       32'h0000_00A5};
    tbl[8]  = '{2, 3'b001, 32'h0000_0206, 32'hABCD_1234, 32'h0,       1, 0, 0, 4'b1100, 32'h1234_1234, 32'h0};
    tbl[9]  = '{1, 3'b001, 32'h0000_0103, 32'h0,         32'h0,       0, 0, 1, 4'b0000, 32'h0,         32'h0};
    tbl[10] = '{1, 3'b010, 32'h0000_010C, 32'h0,         32'hCAFE_F00D, 2, 3, 0, 4'b1111, 32'h0,       32'hCAFE_F00D};
    tbl[11] = '{2, 3'b010, 32'h0000_0302, 32'h1111_2222, 32'h0,       0, 0, 1, 4'b0000, 32'h0,         32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_memwb_valid", {31'd0, memwb_valid_o}, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    check("rst_stall", {31'd0, stall_m_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_memwb_alu", memwb_o.ALUResult, 32'd0);
    check("rst_memwb_rw", {31'd0, memwb_o.RegWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    @(negedge clk);
    exmem_valid_i = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", sbq.size(), 32'd0);

    // Reset while a load waits for its response.
    @(negedge clk);
    exmem_i           = '0;
    exmem_i.RegWrite  = 1'b1;
    exmem_i.ResultSrc = 2'b01;
    exmem_i.funct3    = 3'b010;
    exmem_i.ALUResult = 32'h0000_0400;
    exmem_i.Rd        = 5'd20;
    exmem_valid_i     = 1'b1;
    dmem_gnt_i        = 1'b1;
    $display("txn reset-during-load addr=%h", exmem_i.ALUResult);
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    check("wait_stall_before_rst", {31'd0, stall_m_o}, 32'd1);
    rst_n         = 1'b0;
    exmem_valid_i = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall_m_o}, 32'd0);
    check("midrst_req", {31'd0, dmem_req_o}, 32'd0);
    check("midrst_memwb_valid", {31'd0, memwb_valid_o}, 32'd0);
    check("midrst_memwb_rw", {31'd0, memwb_o.RegWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFF_FFFF;
    #1;
    check("late_rvalid_stall", {31'd0, stall_m_o}, 32'd0);
    @(posedge clk); #1;
    check("late_rvalid_valid", {31'd0, memwb_valid_o}, 32'd0);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;

    // Stray response under a pass-through op must not leak into load_data.
    exmem_i           = '0;
    exmem_i.RegWrite  = 1'b1;
    exmem_i.ALUResult = 32'h0000_0777;
    exmem_i.Rd        = 5'd21;
    exmem_valid_i     = 1'b1;
    dmem_rvalid_i     = 1'b1;
    sbq.push_back('{rw: 1'b1, chk_load: 1'b1, alu: 32'h0000_0777, load: 32'h0, rd: 5'd21});
    $display("txn stray-rvalid alu=%h", exmem_i.ALUResult);
    #1;
    check("stray_stall", {31'd0, stall_m_o}, 32'd0);
    @(negedge clk);
    exmem_valid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_final", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
